bram_capture_ctrl: RTL and testbench

- Sequences writes of one DSP sample stream into one BRAM_WRITEn port (256-bit data, byte write-enables) of the PL/PS buffer interface.
- Software arms it through localbus registers. A hardware trigger then starts a capture after a delay, with optional decimation and a fixed length.
- Status (state, word count, done) goes back to localbus readback so the PS can read the buffer over AXI BRAM.
- Placed in the DSP clock domain, one instance per write buffer.

---
 rtl/bram_capture_ctrl_pkg.sv | 23 ++
 rtl/bram_capture_ctrl_if.sv | 15 +
 rtl/bram_capture_ctrl_decim.sv | 28 ++
 rtl/bram_capture_ctrl.sv | 111 +++++++++++
 tb/tb_bram_capture_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_capture_ctrl_pkg.sv
// Shared types and readback codes for the BRAM capture controller.
// The state codes double as the localbus readback encoding.
package bram_capture_pkg;

  localparam logic [2:0] STATE_CODE_IDLE    = 3'd0;
  localparam logic [2:0] STATE_CODE_ARMED   = 3'd1;
  localparam logic [2:0] STATE_CODE_DELAY   = 3'd2;
  localparam logic [2:0] STATE_CODE_CAPTURE = 3'd3;
  localparam logic [2:0] STATE_CODE_DONE    = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = STATE_CODE_IDLE,
    ARMED   = STATE_CODE_ARMED,
    DELAY   = STATE_CODE_DELAY,
    CAPTURE = STATE_CODE_CAPTURE,
    DONE    = STATE_CODE_DONE
  } capture_state_t;

  function automatic logic is_busy(input capture_state_t s);
    return (s == ARMED) || (s == DELAY) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/bram_capture_ctrl_if.sv
// One BRAM write port (word address, byte enables, data) of the PL/PS buffer.
interface bram_capture_ctrl_if
  import bram_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 256
);
  logic                    en;
  logic [DATA_WIDTH/8-1:0] we;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   din;

  modport master (output en, we, addr, din);
  modport slave  (input  en, we, addr, din);
endinterface

// File: rtl/bram_capture_ctrl_decim.sv
// Decimation strobe: passes the first valid sample after load, then one of
// every decim+1 valid samples.
module capture_decim #(
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   load,
  input  logic                   valid,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic                   accept
);
  logic [DECIM_WIDTH-1:0] cnt_reg;

  assign accept = valid && (cnt_reg == '0);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= decim;
    end else if (valid) begin
      cnt_reg <= cnt_reg - DECIM_WIDTH'(1);
    end
  end
endmodule

// File: rtl/bram_capture_ctrl.sv
// Armed, triggered, optionally delayed and decimated one-shot capture of a
// sample stream into a BRAM write port, with state/count/done readback.
module bram_capture_ctrl
  import bram_capture_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 256,
  parameter int DELAY_WIDTH = 16,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   aresetn,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trig,
  input  logic [ADDR_WIDTH:0]    cfg_len,
  input  logic [DELAY_WIDTH-1:0] cfg_delay,
  input  logic [DECIM_WIDTH-1:0] cfg_decim,
  input  logic                   s_valid,
  input  logic [DATA_WIDTH-1:0]  s_data,
  bram_capture_ctrl_if.master    bram,
  output logic [2:0]             state,
  output logic [ADDR_WIDTH:0]    count,
  output logic                   busy,
  output logic                   done
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  capture_state_t         state_reg, state_next;
  logic [ADDR_WIDTH:0]    len_reg, count_reg, count_inc, clamped_len;
  logic [DELAY_WIDTH-1:0] delay_cnt_reg;
  logic [DECIM_WIDTH-1:0] decim_reg;
  logic                   wr_en_reg, done_reg;
  logic [DATA_WIDTH-1:0]  din_reg;
  logic                   arm_ok, last_write, capture_valid, accept;

  assign arm_ok      = arm && !abort && (state_reg == IDLE || state_reg == DONE);
  assign clamped_len = (cfg_len > DEPTH) ? DEPTH : cfg_len;
  assign count_inc   = count_reg + (ADDR_WIDTH+1)'(1);
  assign last_write  = wr_en_reg && (count_inc == len_reg);
  // Block the sample arriving alongside the final write so nothing trails DONE.
  assign capture_valid = s_valid && (state_reg == CAPTURE) && !last_write;

  capture_decim #(.DECIM_WIDTH(DECIM_WIDTH)) u_decim (
    .clk     (clk),
    .aresetn (aresetn),
    .load    (arm_ok),
    .valid   (capture_valid),
    .decim   (decim_reg),
    .accept  (accept)
  );

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, DONE: if (arm) state_next = (clamped_len == '0) ? DONE : ARMED;
        ARMED:      if (trig) state_next = (delay_cnt_reg != '0) ? DELAY : CAPTURE;
        DELAY:      if (s_valid && delay_cnt_reg == DELAY_WIDTH'(1)) state_next = CAPTURE;
        CAPTURE:    if (last_write) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      len_reg       <= '0;
      count_reg     <= '0;
      delay_cnt_reg <= '0;
      decim_reg     <= '0;
      wr_en_reg     <= 1'b0;
      din_reg       <= '0;
      done_reg      <= 1'b0;
    end else begin
      wr_en_reg <= accept && !abort;
      if (accept) din_reg <= s_data;
      // A write already on the port in the abort cycle still lands and counts.
      if (wr_en_reg) count_reg <= count_inc;
      if (abort) begin
        done_reg <= 1'b0;
      end else if (arm_ok) begin
        len_reg       <= clamped_len;
        delay_cnt_reg <= cfg_delay;
        decim_reg     <= cfg_decim;
        count_reg     <= '0;
        done_reg      <= (clamped_len == '0);
      end else begin
        if (state_reg == DELAY && s_valid) delay_cnt_reg <= delay_cnt_reg - DELAY_WIDTH'(1);
        if (last_write) done_reg <= 1'b1;
      end
    end
  end

  assign bram.en   = wr_en_reg;
  assign bram.we   = {(DATA_WIDTH/8){wr_en_reg}};
  assign bram.addr = count_reg[ADDR_WIDTH-1:0];
  assign bram.din  = din_reg;

  assign state = state_reg;
  assign count = count_reg;
  assign busy  = is_busy(state_reg);
  assign done  = done_reg;
endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Directed bench for bram_capture_ctrl; a negedge monitor logs every BRAM write.
module tb_bram_capture_ctrl;
  localparam int AW  = 13;
  localparam int DW  = 256;
  localparam int DLW = 16;
  localparam int DCW = 8;

  logic           clk = 1'b0;
  logic           aresetn = 1'b0;
  logic           arm = 1'b0, abort = 1'b0, trig = 1'b0, s_valid = 1'b0;
  logic [AW:0]    cfg_len = '0;
  logic [DLW-1:0] cfg_delay = '0;
  logic [DCW-1:0] cfg_decim = '0;
  logic [DW-1:0]  s_data = '0;
  logic [2:0]     state;
  logic [AW:0]    count;
  logic           busy, done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit quiet = 1'b0;

  logic [AW-1:0]   wa_q[$];
  logic [DW-1:0]   wd_q[$];
  logic [DW/8-1:0] ww_q[$];
  int              wc_q[$];

  bram_capture_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bram_if ();

  bram_capture_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DELAY_WIDTH(DLW), .DECIM_WIDTH(DCW)
  ) dut (
    .clk(clk), .aresetn(aresetn), .arm(arm), .abort(abort), .trig(trig),
    .cfg_len(cfg_len), .cfg_delay(cfg_delay), .cfg_decim(cfg_decim),
    .s_valid(s_valid), .s_data(s_data), .bram(bram_if),
    .state(state), .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bram_if.en === 1'b1) begin
      wa_q.push_back(bram_if.addr);
      wd_q.push_back(bram_if.din);
      ww_q.push_back(bram_if.we);
      wc_q.push_back(cyc);
      if (!quiet) $display("write cyc=%0d addr=%0d data=%0h", cyc, bram_if.addr, bram_if.din);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete within time budget");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wa_q.delete(); wd_q.delete(); ww_q.delete(); wc_q.delete();
  endtask

  task automatic arm_cfg(input logic [AW:0] len, input logic [DLW-1:0] dly, input logic [DCW-1:0] dec);
    cfg_len = len; cfg_delay = dly; cfg_decim = dec;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bram_if.en !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", bram_if.en); end
    checks++; if (bram_if.we !== '0) begin failures++; $display("FAIL reset_we got=%0h exp=0", bram_if.we); end
    checks++; if (bram_if.addr !== '0 || bram_if.din !== '0) begin failures++; $display("FAIL reset_addr_din got=%0h/%0h exp=0/0", bram_if.addr, bram_if.din); end
    checks++; if (state !== 3'd0 || count !== '0) begin failures++; $display("FAIL reset_state_count got=%0d/%0d exp=0/0", state, count); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_busy_done got=%0b/%0b exp=0/0", busy, done); end
    #20;
    aresetn = 1'b1;
    tick();
    $display("test_reset complete");
  endtask

  task automatic test_basic();
    int c0;
    logic [DW-1:0] exp_d;
    clear_q();
    arm_cfg(14'd4, 16'd0, 8'd0);
    checks++; if (state !== 3'd1 || busy !== 1'b1) begin failures++; $display("FAIL basic_armed state/busy got=%0d/%0b exp=1/1", state, busy); end
    trig = 1'b1; s_valid = 1'b1; s_data = 'hEE;
    tick();
    trig = 1'b0;
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL basic_capture state got=%0d exp=3", state); end
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      s_data = DW'(32'h10 + i);
      tick();
    end
    s_valid = 1'b0;
    checks++; if (wa_q.size() != 4) begin failures++; $display("FAIL basic_nwrites got=%0d exp=4", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 4; i++) begin
      exp_d = DW'(32'h10 + i);
      checks++; if (wa_q[i] !== AW'(i) || wd_q[i] !== exp_d) begin failures++; $display("FAIL basic_write%0d addr/data got=%0d/%0h exp=%0d/%0h", i, wa_q[i], wd_q[i], i, exp_d); end
      checks++; if (ww_q[i] !== {(DW/8){1'b1}}) begin failures++; $display("FAIL basic_we%0d got=%0h exp=all ones", i, ww_q[i]); end
      checks++; if (wc_q[i] != c0 + 1 + i) begin failures++; $display("FAIL basic_latency%0d got=%0d exp=%0d", i, wc_q[i], c0 + 1 + i); end
    end
    checks++; if (done !== 1'b1 || count !== 14'd4) begin failures++; $display("FAIL basic_done done/count got=%0b/%0d exp=1/4", done, count); end
    checks++; if (state !== 3'd4 || busy !== 1'b0) begin failures++; $display("FAIL basic_final state/busy got=%0d/%0b exp=4/0", state, busy); end
    $display("test_basic complete writes=%0d", wa_q.size());
  endtask

  task automatic test_delay();
    clear_q();
    arm_cfg(14'd2, 16'd3, 8'd0);
    checks++; if (state !== 3'd1 || count !== '0 || done !== 1'b0) begin failures++; $display("FAIL rearm state/count/done got=%0d/%0d/%0b exp=1/0/0", state, count, done); end
    trig = 1'b1; s_valid = 1'b1; s_data = 'hEE;
    tick();
    trig = 1'b0;
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL delay_enter state got=%0d exp=2", state); end
    for (int i = 0; i < 10; i++) begin
      s_data = DW'(i);
      tick();
      if (i == 1) begin
        checks++; if (state !== 3'd2) begin failures++; $display("FAIL delay_hold state got=%0d exp=2", state); end
      end
      if (i == 2) begin
        checks++; if (state !== 3'd3) begin failures++; $display("FAIL delay_to_capture state got=%0d exp=3", state); end
      end
    end
    s_valid = 1'b0;
    checks++; if (wa_q.size() != 2) begin failures++; $display("FAIL delay_nwrites got=%0d exp=2", wa_q.size()); end
    if (wa_q.size() == 2) begin
      checks++; if (wa_q[0] !== 13'd0 || wd_q[0] !== DW'(3)) begin failures++; $display("FAIL delay_write0 addr/data got=%0d/%0h exp=0/3", wa_q[0], wd_q[0]); end
      checks++; if (wa_q[1] !== 13'd1 || wd_q[1] !== DW'(4)) begin failures++; $display("FAIL delay_write1 addr/data got=%0d/%0h exp=1/4", wa_q[1], wd_q[1]); end
    end
    checks++; if (state !== 3'd4 || done !== 1'b1) begin failures++; $display("FAIL delay_done state/done got=%0d/%0b exp=4/1", state, done); end
    $display("test_delay complete writes=%0d", wa_q.size());
  endtask

  task automatic test_decim();
    int vidx;
    logic [DW-1:0] exp_d;
    clear_q();
    arm_cfg(14'd3, 16'd0, 8'd2);
    trig = 1'b1; s_valid = 1'b0;
    tick();
    trig = 1'b0;
    vidx = 0;
    for (int k = 0; k < 20; k++) begin
      s_valid = (k % 2 == 0);
      s_data = DW'(32'h100 + vidx);
      if (s_valid) vidx++;
      tick();
    end
    s_valid = 1'b0;
    checks++; if (wa_q.size() != 3) begin failures++; $display("FAIL decim_nwrites got=%0d exp=3", wa_q.size()); end
    for (int i = 0; i < wa_q.size() && i < 3; i++) begin
      exp_d = DW'(32'h100 + 3 * i);
      checks++; if (wa_q[i] !== AW'(i) || wd_q[i] !== exp_d) begin failures++; $display("FAIL decim_write%0d addr/data got=%0d/%0h exp=%0d/%0h", i, wa_q[i], wd_q[i], i, exp_d); end
    end
    checks++; if (done !== 1'b1 || count !== 14'd3) begin failures++; $display("FAIL decim_done done/count got=%0b/%0d exp=1/3", done, count); end
    $display("test_decim complete writes=%0d", wa_q.size());
  endtask

  task automatic test_abort();
    clear_q();
    arm_cfg(14'd8, 16'd0, 8'd0);
    trig = 1'b1; s_valid = 1'b1; s_data = 'hEE;
    tick();
    trig = 1'b0;
    for (int i = 0; i < 8; i++) begin
      s_data = DW'(32'h20 + i);
      abort = (i == 3);
      tick();
      if (i == 3) begin
        checks++; if (bram_if.en !== 1'b0) begin failures++; $display("FAIL abort_no_write en got=%0b exp=0", bram_if.en); end
      end
      abort = 1'b0;
    end
    s_valid = 1'b0;
    checks++; if (wa_q.size() != 3) begin failures++; $display("FAIL abort_nwrites got=%0d exp=3", wa_q.size()); end
    if (wa_q.size() == 3) begin
      checks++; if (wa_q[2] !== 13'd2 || wd_q[2] !== DW'(32'h22)) begin failures++; $display("FAIL abort_last addr/data got=%0d/%0h exp=2/22", wa_q[2], wd_q[2]); end
    end
    checks++; if (state !== 3'd0 || done !== 1'b0) begin failures++; $display("FAIL abort_state state/done got=%0d/%0b exp=0/0", state, done); end
    checks++; if (count !== 14'd3 || busy !== 1'b0) begin failures++; $display("FAIL abort_count count/busy got=%0d/%0b exp=3/0", count, busy); end
    $display("test_abort complete writes=%0d", wa_q.size());
  endtask

  task automatic test_len_zero();
    clear_q();
    arm_cfg(14'd0, 16'd0, 8'd0);
    checks++; if (state !== 3'd4 || done !== 1'b1 || count !== '0) begin failures++; $display("FAIL len0 state/done/count got=%0d/%0b/%0d exp=4/1/0", state, done, count); end
    trig = 1'b1; s_valid = 1'b1;
    tick(); tick();
    trig = 1'b0; s_valid = 1'b0;
    tick();
    checks++; if (wa_q.size() != 0) begin failures++; $display("FAIL len0_nwrites got=%0d exp=0", wa_q.size()); end
    $display("test_len_zero complete writes=%0d", wa_q.size());
  endtask

  task automatic test_ignored();
    clear_q();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (state !== 3'd0 || done !== 1'b0) begin failures++; $display("FAIL abort_from_done state/done got=%0d/%0b exp=0/0", state, done); end
    trig = 1'b1; s_valid = 1'b1; s_data = 'h55;
    tick(); tick(); tick();
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL trig_in_idle state got=%0d exp=0", state); end
    cfg_len = 14'd2; cfg_delay = '0; cfg_decim = '0;
    arm = 1'b1;
    tick();
    arm = 1'b0; trig = 1'b0;
    tick(); tick();
    checks++; if (state !== 3'd1 || wa_q.size() != 0) begin failures++; $display("FAIL trig_in_arm_cycle state/writes got=%0d/%0d exp=1/0", state, wa_q.size()); end
    s_valid = 1'b0; trig = 1'b1;
    tick();
    trig = 1'b0;
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL ignored_capture state got=%0d exp=3", state); end
    cfg_len = 14'd7;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    checks++; if (state !== 3'd3 || count !== '0) begin failures++; $display("FAIL arm_in_capture state/count got=%0d/%0d exp=3/0", state, count); end
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = DW'(32'h60 + i);
      tick();
    end
    s_valid = 1'b0;
    checks++; if (wa_q.size() != 2 || count !== 14'd2 || state !== 3'd4) begin failures++; $display("FAIL arm_in_capture_len writes/count/state got=%0d/%0d/%0d exp=2/2/4", wa_q.size(), count, state); end
    $display("test_ignored complete writes=%0d", wa_q.size());
  endtask

  task automatic test_clamp();
    int bad;
    clear_q();
    quiet = 1'b1;
    arm_cfg(14'h2001, 16'd0, 8'd0);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL clamp_armed state got=%0d exp=1", state); end
    trig = 1'b1; s_valid = 1'b1; s_data = 'hEE;
    tick();
    trig = 1'b0;
    for (int i = 0; i < 8200; i++) begin
      s_data = DW'(i);
      tick();
    end
    s_valid = 1'b0;
    quiet = 1'b0;
    checks++; if (wa_q.size() != 8192) begin failures++; $display("FAIL clamp_nwrites got=%0d exp=8192", wa_q.size()); end
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wa_q[i] !== i[AW-1:0] || wd_q[i] !== DW'(i)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL clamp_sequence bad_writes got=%0d exp=0", bad); end
    if (wa_q.size() > 0) begin
      checks++; if (wa_q[wa_q.size()-1] !== 13'd8191) begin failures++; $display("FAIL clamp_last_addr got=%0d exp=8191", wa_q[wa_q.size()-1]); end
    end
    checks++; if (count !== 14'd8192 || state !== 3'd4 || done !== 1'b1) begin failures++; $display("FAIL clamp_done count/state/done got=%0d/%0d/%0b exp=8192/4/1", count, state, done); end
    $display("test_clamp complete writes=%0d", wa_q.size());
  endtask

  task automatic test_async_reset();
    clear_q();
    arm_cfg(14'd8, 16'd0, 8'd0);
    trig = 1'b1; s_valid = 1'b1;
    tick();
    trig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_data = DW'(32'h40 + i);
      tick();
    end
    #2 aresetn = 1'b0;
    #1;
    checks++; if (bram_if.en !== 1'b0 || bram_if.we !== '0) begin failures++; $display("FAIL areset_en_we got=%0b/%0h exp=0/0", bram_if.en, bram_if.we); end
    checks++; if (bram_if.addr !== '0 || bram_if.din !== '0) begin failures++; $display("FAIL areset_addr_din got=%0h/%0h exp=0/0", bram_if.addr, bram_if.din); end
    checks++; if (state !== 3'd0 || count !== '0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL areset_status state/count/busy/done got=%0d/%0d/%0b/%0b exp=0/0/0/0", state, count, busy, done); end
    s_valid = 1'b0;
    @(negedge clk);
    #2 aresetn = 1'b1;
    tick();
    clear_q();
    arm_cfg(14'd1, 16'd0, 8'd0);
    trig = 1'b1;
    tick();
    trig = 1'b0; s_valid = 1'b1; s_data = 'hAB;
    tick();
    s_valid = 1'b0;
    tick();
    checks++; if (wa_q.size() != 1) begin failures++; $display("FAIL post_reset_nwrites got=%0d exp=1", wa_q.size()); end
    if (wa_q.size() == 1) begin
      checks++; if (wa_q[0] !== 13'd0 || wd_q[0] !== DW'(32'hAB)) begin failures++; $display("FAIL post_reset_write addr/data got=%0d/%0h exp=0/ab", wa_q[0], wd_q[0]); end
    end
    checks++; if (done !== 1'b1 || count !== 14'd1) begin failures++; $display("FAIL post_reset_done done/count got=%0b/%0d exp=1/1", done, count); end
    $display("test_async_reset complete");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_decim();
    test_abort();
    test_len_zero();
    test_ignored();
    test_clamp();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
